// File: rtl/udp_fragment_slot_buffer.sv
// Per-fragment-slot byte store behind udp_receieve_handler; completed slots drain round-robin on a valid/ready byte stream.
// Optional idle discard of FILLING slots is enabled by defining UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN.
module udp_fragment_slot_buffer #(
    parameter int FRAGMENT_SLOTS = 4,
    parameter int SLOT_DEPTH     = 2048,
    parameter int STALE_TIMEOUT  = 65535
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [7:0]                        push_data,
    input  logic [FRAGMENT_SLOTS-1:0]         push_data_valid,
    input  logic [FRAGMENT_SLOTS-1:0]         push_data_last,
    input  logic [15:0]                       packet_id,
    output logic [FRAGMENT_SLOTS-1:0]         fragment_slot_empty,
    output logic [FRAGMENT_SLOTS*16-1:0]      fragment_slot_packet_id,
    output logic [7:0]                        pop_data,
    output logic                              pop_data_valid,
    output logic                              pop_data_last,
    input  logic                              pop_data_ready,
    output logic [$clog2(FRAGMENT_SLOTS)-1:0] pop_slot,
    output logic                              overflow_drop,
    output logic                              stale_drop
);

    localparam int SW = $clog2(FRAGMENT_SLOTS);
    localparam int AW = $clog2(SLOT_DEPTH);
    localparam int CW = AW + 1;

    if (STALE_TIMEOUT < 1 || STALE_TIMEOUT > 65535) begin : g_bad_timeout
        $error("STALE_TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_COMPLETE, S_DRAINING} slot_state_t;
    typedef enum logic [1:0] {D_IDLE, D_FETCH, D_OUT} drain_state_t;

    slot_state_t   slot_state [FRAGMENT_SLOTS];
    logic [CW-1:0] slot_count [FRAGMENT_SLOTS];
    logic [15:0]   slot_id    [FRAGMENT_SLOTS];
    logic          slot_ovf   [FRAGMENT_SLOTS];
`ifdef UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN
    logic [15:0]   idle_count [FRAGMENT_SLOTS];
`endif

    logic [7:0]    mem [FRAGMENT_SLOTS*SLOT_DEPTH];

    drain_state_t  drain_state;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] cur_slot;
    logic [AW-1:0] rd_addr;

    logic          wr_en;
    logic [SW-1:0] wr_slot;
    logic [AW-1:0] wr_addr;
    logic          pick_found;
    logic [SW-1:0] pick_slot;
    logic [SW-1:0] scan_slot;
    int            scan_idx;

    // Single RAM write port; the handler strobes one slot at a time, lowest index wins otherwise.
    always_comb begin
        wr_en   = 1'b0;
        wr_slot = '0;
        wr_addr = '0;
        for (int i = FRAGMENT_SLOTS - 1; i >= 0; i--) begin
            if (push_data_valid[i] &&
                (slot_state[i] == S_EMPTY ||
                 (slot_state[i] == S_FILLING && slot_count[i] != CW'(SLOT_DEPTH)))) begin
                wr_en   = 1'b1;
                wr_slot = SW'(i);
                wr_addr = (slot_state[i] == S_EMPTY) ? '0 : slot_count[i][AW-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[{wr_slot, wr_addr}] <= push_data;
        end
    end

    // Round-robin scan for the first COMPLETE slot at or after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_slot  = '0;
        scan_idx   = 0;
        scan_slot  = '0;
        for (int k = 0; k < FRAGMENT_SLOTS; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= FRAGMENT_SLOTS) begin
                scan_idx = scan_idx - FRAGMENT_SLOTS;
            end
            scan_slot = SW'(scan_idx);
            if (!pick_found && slot_state[scan_slot] == S_COMPLETE) begin
                pick_found = 1'b1;
                pick_slot  = scan_slot;
            end
        end
    end

    always_comb begin
        fragment_slot_empty     = '0;
        fragment_slot_packet_id = '0;
        for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
            fragment_slot_empty[i]             = (slot_state[i] == S_EMPTY);
            fragment_slot_packet_id[i*16 +: 16] = slot_id[i];
        end
    end

    // Fill side only touches EMPTY/FILLING slots and drain side only COMPLETE/DRAINING ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
                slot_state[i] <= S_EMPTY;
                slot_count[i] <= '0;
                slot_id[i]    <= '0;
                slot_ovf[i]   <= 1'b0;
`ifdef UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN
                idle_count[i] <= '0;
`endif
            end
            drain_state    <= D_IDLE;
            rr_ptr         <= '0;
            cur_slot       <= '0;
            rd_addr        <= '0;
            pop_data       <= '0;
            pop_data_valid <= 1'b0;
            pop_data_last  <= 1'b0;
            pop_slot       <= '0;
            overflow_drop  <= 1'b0;
`ifdef UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN
            stale_drop     <= 1'b0;
`endif
        end else begin
            overflow_drop <= 1'b0;
`ifdef UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN
            stale_drop    <= 1'b0;
`endif
            for (int i = 0; i < FRAGMENT_SLOTS; i++) begin
                case (slot_state[i])
                    S_EMPTY: begin
                        if (push_data_valid[i]) begin
                            slot_state[i] <= push_data_last[i] ? S_COMPLETE : S_FILLING;
                            slot_count[i] <= CW'(1);
                            slot_id[i]    <= packet_id;
                            slot_ovf[i]   <= 1'b0;
`ifdef UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN
                            idle_count[i] <= '0;
`endif
                        end
                    end
                    S_FILLING: begin
                        if (push_data_valid[i]) begin
                            if (slot_count[i] != CW'(SLOT_DEPTH)) begin
                                slot_count[i] <= slot_count[i] + CW'(1);
                            end else begin
                                slot_ovf[i] <= 1'b1;
                            end
                        end
                        // A datagram that spilled past the slot is useless; discard it at its end.
                        if (push_data_last[i]) begin
                            if (slot_ovf[i] ||
                                (push_data_valid[i] && slot_count[i] == CW'(SLOT_DEPTH))) begin
                                slot_state[i] <= S_EMPTY;
                                overflow_drop <= 1'b1;
                            end else begin
                                slot_state[i] <= S_COMPLETE;
                            end
                        end
`ifdef UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN
                        else if (push_data_valid[i]) begin
                            idle_count[i] <= '0;
                        end else if (idle_count[i] == 16'(STALE_TIMEOUT - 1)) begin
                            slot_state[i] <= S_EMPTY;
                            stale_drop    <= 1'b1;
                        end else begin
                            idle_count[i] <= idle_count[i] + 16'd1;
                        end
`endif
                    end
                    default: ;
                endcase
            end

            case (drain_state)
                D_IDLE: begin
                    if (pick_found) begin
                        slot_state[pick_slot] <= S_DRAINING;
                        cur_slot              <= pick_slot;
                        rd_addr               <= '0;
                        drain_state           <= D_FETCH;
                    end
                end
                D_FETCH: begin
                    pop_data       <= mem[{cur_slot, rd_addr}];
                    pop_data_last  <= ({1'b0, rd_addr} == slot_count[cur_slot] - CW'(1));
                    pop_slot       <= cur_slot;
                    pop_data_valid <= 1'b1;
                    drain_state    <= D_OUT;
                end
                D_OUT: begin
                    if (pop_data_ready) begin
                        pop_data_valid <= 1'b0;
                        pop_data_last  <= 1'b0;
                        if (pop_data_last) begin
                            slot_state[cur_slot] <= S_EMPTY;
                            rr_ptr      <= (cur_slot == SW'(FRAGMENT_SLOTS - 1)) ? '0 : cur_slot + SW'(1);
                            drain_state <= D_IDLE;
                        end else begin
                            rd_addr     <= rd_addr + AW'(1);
                            drain_state <= D_FETCH;
                        end
                    end
                end
                default: drain_state <= D_IDLE;
            endcase
        end
    end

`ifndef UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN
    assign stale_drop = 1'b0;
`endif

endmodule

// File: tb/tb_udp_fragment_slot_buffer.sv
// Scoreboard bench for udp_fragment_slot_buffer: stimulus queues expected pop beats, a monitor checks them.
module tb_udp_fragment_slot_buffer;

    localparam int SLOTS   = 4;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 100;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  push_data = '0;
    logic [3:0]  push_data_valid = '0;
    logic [3:0]  push_data_last = '0;
    logic [15:0] packet_id = '0;
    logic [3:0]  fragment_slot_empty;
    logic [63:0] fragment_slot_packet_id;
    logic [7:0]  pop_data;
    logic        pop_data_valid;
    logic        pop_data_last;
    logic        pop_data_ready = 1'b1;
    logic [1:0]  pop_slot;
    logic        overflow_drop;
    logic        stale_drop;

    always #5 clock = ~clock;

    udp_fragment_slot_buffer #(
        .FRAGMENT_SLOTS(SLOTS),
        .SLOT_DEPTH(DEPTH),
        .STALE_TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .push_data(push_data),
        .push_data_valid(push_data_valid),
        .push_data_last(push_data_last),
        .packet_id(packet_id),
        .fragment_slot_empty(fragment_slot_empty),
        .fragment_slot_packet_id(fragment_slot_packet_id),
        .pop_data(pop_data),
        .pop_data_valid(pop_data_valid),
        .pop_data_last(pop_data_last),
        .pop_data_ready(pop_data_ready),
        .pop_slot(pop_slot),
        .overflow_drop(overflow_drop),
        .stale_drop(stale_drop)
    );

    typedef struct packed {
        logic [1:0] slot;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb_q[$];
    int    total = 0;
    int    bad = 0;
    int    ovf_seen = 0;
    int    stale_seen = 0;
    logic  held_valid = 1'b0;
    beat_t held_beat;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        beat_t got;
        beat_t exp_beat;
        got = '{slot: pop_slot, data: pop_data, last: pop_data_last};
        if (!reset_n) begin
            held_valid = 1'b0;
        end else begin
            if (overflow_drop) ovf_seen++;
            if (stale_drop) stale_seen++;
            if (held_valid && pop_data_valid) check_output("stall_hold", 64'(got), 64'(held_beat));
            held_valid = pop_data_valid && !pop_data_ready;
            held_beat  = got;
            if (pop_data_valid && pop_data_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_pop: got 0x%0h expected no beat", got);
                end else begin
                    exp_beat = sb_q.pop_front();
                    check_output("pop_beat", 64'(got), 64'(exp_beat));
                end
            end
        end
    end

    task automatic expect_beat(input int slot, input logic [7:0] data, input logic last);
        sb_q.push_back('{slot: 2'(slot), data: data, last: last});
    endtask

    task automatic apply_stimulus(input int slot, input logic [7:0] data, input logic last, input logic [15:0] id);
        push_data       = data;
        push_data_valid = 4'(1 << slot);
        push_data_last  = last ? 4'(1 << slot) : 4'b0000;
        packet_id       = id;
        @(posedge clock); #1;
        push_data_valid = '0;
        push_data_last  = '0;
    endtask

    task automatic push_last(input logic [3:0] mask);
        push_data_last = mask;
        @(posedge clock); #1;
        push_data_last = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clock); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d beats left expected 0", sb_q.size());
            sb_q.delete();
        end
        tick(2);
    endtask

    initial begin
        int base;
        int n;

        reset_n = 1'b0;
        tick(3);
        check_output("reset_empty", 64'(fragment_slot_empty), 64'hF);
        check_output("reset_ids", fragment_slot_packet_id, 64'h0);
        check_output("reset_pop", {pop_data_valid, pop_data_last, pop_data, pop_slot}, 64'h0);
        check_output("reset_drops", {overflow_drop, stale_drop}, 64'h0);
        @(negedge clock) reset_n = 1'b1;
        tick(1);

        // Ten bytes into slot 0; id must be the one seen with the first byte.
        apply_stimulus(0, 8'h00, 1'b0, 16'h1234);
        check_output("t1_empty_after_first", 64'(fragment_slot_empty[0]), 64'h0);
        for (int b = 1; b < 10; b++) apply_stimulus(0, 8'(b), 1'b0, 16'hBEEF);
        for (int b = 0; b < 10; b++) expect_beat(0, 8'(b), b == 9);
        push_last(4'b0001);
        check_output("t1_complete_not_empty", 64'(fragment_slot_empty[0]), 64'h0);
        check_output("t1_id", 64'(fragment_slot_packet_id[15:0]), 64'h1234);
        wait_drain(100);
        check_output("t1_empty_after_drain", 64'(fragment_slot_empty[0]), 64'h1);

        // valid and last together on the third byte of slot 1.
        expect_beat(1, 8'hA0, 1'b0);
        expect_beat(1, 8'hA1, 1'b0);
        expect_beat(1, 8'hA2, 1'b1);
        apply_stimulus(1, 8'hA0, 1'b0, 16'h0002);
        apply_stimulus(1, 8'hA1, 1'b0, 16'h0002);
        apply_stimulus(1, 8'hA2, 1'b1, 16'h0002);
        check_output("t2_id", 64'(fragment_slot_packet_id[31:16]), 64'h0002);
        wait_drain(50);
        check_output("t2_empty_after_drain", 64'(fragment_slot_empty[1]), 64'h1);

        // Overflow: DEPTH+5 bytes then last; slot dropped, nothing popped.
        base = ovf_seen;
        for (int b = 0; b < DEPTH + 5; b++) apply_stimulus(2, 8'(b + 8'h80), 1'b0, 16'h0003);
        check_output("t3_filling", 64'(fragment_slot_empty[2]), 64'h0);
        push_last(4'b0100);
        check_output("t3_empty_after_drop", 64'(fragment_slot_empty[2]), 64'h1);
        tick(6);
        check_output("t3_overflow_pulses", 64'(ovf_seen - base), 64'd1);

        // Reset brings the round-robin pointer back to slot 0.
        @(negedge clock) reset_n = 1'b0;
        tick(2);
        @(negedge clock) reset_n = 1'b1;
        tick(1);

        // Slots 0,2,3 complete on the same cycle; drained in order 0,2,3.
        apply_stimulus(0, 8'h10, 1'b0, 16'h0010);
        apply_stimulus(0, 8'h11, 1'b0, 16'h0010);
        apply_stimulus(2, 8'h20, 1'b0, 16'h0020);
        apply_stimulus(2, 8'h21, 1'b0, 16'h0020);
        apply_stimulus(2, 8'h22, 1'b0, 16'h0020);
        apply_stimulus(3, 8'h30, 1'b0, 16'h0030);
        expect_beat(0, 8'h10, 1'b0);
        expect_beat(0, 8'h11, 1'b1);
        expect_beat(2, 8'h20, 1'b0);
        expect_beat(2, 8'h21, 1'b0);
        expect_beat(2, 8'h22, 1'b1);
        expect_beat(3, 8'h30, 1'b1);
        push_last(4'b1101);
        wait_drain(100);

        // Same again with the consumer stalling two cycles out of three.
        pop_data_ready = 1'b0;
        apply_stimulus(0, 8'h40, 1'b0, 16'h0040);
        apply_stimulus(0, 8'h41, 1'b0, 16'h0040);
        apply_stimulus(0, 8'h42, 1'b0, 16'h0040);
        apply_stimulus(2, 8'h50, 1'b0, 16'h0050);
        apply_stimulus(3, 8'h60, 1'b0, 16'h0060);
        apply_stimulus(3, 8'h61, 1'b0, 16'h0060);
        expect_beat(0, 8'h40, 1'b0);
        expect_beat(0, 8'h41, 1'b0);
        expect_beat(0, 8'h42, 1'b1);
        expect_beat(2, 8'h50, 1'b1);
        expect_beat(3, 8'h60, 1'b0);
        expect_beat(3, 8'h61, 1'b1);
        push_last(4'b1101);
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            pop_data_ready = (n % 3 == 2);
            @(posedge clock); #1;
            n++;
        end
        pop_data_ready = 1'b1;
        wait_drain(50);
        check_output("t4_all_empty", 64'(fragment_slot_empty), 64'hF);

        // Idle FILLING slot 3.
        base = stale_seen;
        for (int b = 0; b < 4; b++) apply_stimulus(3, 8'(b + 8'h70), 1'b0, 16'h0070);
`ifdef UDP_FRAGMENT_SLOT_STALE_TIMEOUT_EN
        n = 0;
        while (!stale_drop && n < 150) begin
            @(posedge clock); #1;
            n++;
        end
        check_output("t5_stale_idle_cycles", 64'(n), 64'd100);
        check_output("t5_empty_after_stale", 64'(fragment_slot_empty[3]), 64'h1);
        tick(3);
        check_output("t5_stale_pulses", 64'(stale_seen - base), 64'd1);
`else
        tick(150);
        check_output("t5_still_filling", 64'(fragment_slot_empty[3]), 64'h0);
        check_output("t5_no_stale", 64'(stale_seen - base), 64'd0);
`endif

        // Reset while a beat is being presented.
        pop_data_ready = 1'b0;
        for (int b = 0; b < 5; b++) apply_stimulus(1, 8'(b + 8'hC0), 1'b0, 16'h00C0);
        push_last(4'b0010);
        n = 0;
        while (!pop_data_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check_output("t6_valid_before_reset", 64'(pop_data_valid), 64'h1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_output("t6_valid_in_reset", 64'(pop_data_valid), 64'h0);
        check_output("t6_empty_in_reset", 64'(fragment_slot_empty), 64'hF);
        tick(2);
        @(negedge clock) reset_n = 1'b1;
        pop_data_ready = 1'b1;
        tick(10);
        check_output("t6_idle_after_reset", {pop_data_valid, 4'(fragment_slot_empty)}, 64'h0F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
